pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS-32 core. It sits beside the IF/ID and ID/EX pipeline registers and drives their `stall` and `flush` inputs, plus the PC and IF/ID write enables. It detects load-use hazards and inserts a programmable number of bubbles, and it sequences multi-cycle flushes after a taken branch. A small FSM carries each hazard across the cycles in which the pipeline state no longer shows it.

## Interface
Parameters:
- LU_STALL_CYCLES, 1, bubbles per load-use hazard (1 with MEM forwarding, 2 without); legal 1..3
- FLUSH_CYCLES, 2, cycles flush held after branch_taken (branch resolved in EX/MEM); legal 1..3
- CNT_W, 16, perf counter width (macro only)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- id_ex_memRead  in  1  instruction in EX is a load
- id_ex_rt  in  5  load destination register
- if_id_rs  in  5  rs of the instruction in ID
- if_id_rt  in  5  rt of the instruction in ID
- branch_taken  in  1  taken branch resolved this cycle
- stall  out  1  to ID/EX: load a bubble (clears the register)
- flush  out  1  to IF/ID and ID/EX: clear wrong-path instructions
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- ctrl_state  out  2  FSM state (debug)
- stall_cycles, flush_cycles  out  CNT_W  perf counters (only under macro)

## Operation
- The load-use hit `lu_hit` = id_ex_memRead && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt).
- FSM states: RUN=0, STALL=1, FLUSH=2. A 2-bit down-counter `rem` tracks the remaining cycles.
- RUN:
  - If branch_taken: flush=1. If FLUSH_CYCLES>1, go to FLUSH with rem=FLUSH_CYCLES-1.
  - Else if lu_hit: stall=1, pc_write=0, if_id_write=0. If LU_STALL_CYCLES>1, go to STALL with rem=LU_STALL_CYCLES-1.
  - Else: all pass (pc_write=1, if_id_write=1, stall=0, flush=0).
- STALL:
  - Outputs are the same as a RUN lu_hit, regardless of the current lu_hit. This is needed because the bubble has cleared id_ex_memRead.
  - rem decrements each cycle. At rem==1 the FSM returns to RUN.
- FLUSH:
  - flush=1, pc_write=1, if_id_write=1.
  - rem decrements each cycle. At rem==1 the FSM returns to RUN.
- Output priority: flush > stall > pass. stall and flush are never high together.
- Simultaneous events:
  - branch_taken in STALL: abort the stall, assert flush that cycle, and enter FLUSH (or RUN if FLUSH_CYCLES==1).
  - lu_hit in FLUSH: ignored.
  - branch_taken in FLUSH: ignored; it is wrong-path.
  - lu_hit in the cycle of the return to RUN: evaluated normally.

## Timing
- Outputs are combinational from state, rem and the current inputs, with zero-cycle latency to the pipeline-register enables. State and rem are registered.
- Reset, when reset==0 at a clk edge: state=RUN, rem=0, counters=0.
- While reset==0, outputs are forced to stall=0, flush=0, pc_write=0, if_id_write=0, ctrl_state=0.
- Reset mid-STALL or mid-FLUSH aborts the sequence. The first cycle after reset release is RUN.
- Load-use costs exactly LU_STALL_CYCLES cycles of pc_write=0. A taken branch costs exactly FLUSH_CYCLES cycles of flush=1.

## Configuration
- HAZARD_PERF_CNT_EN:
  - Defined: stall_cycles and flush_cycles ports exist. They increment on each cycle with stall=1 or flush=1, saturate at all-ones, and clear on reset.
  - Undefined: the ports and logic are absent. The FSM behaviour is identical in both builds.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state encoding constants RUN/STALL/FLUSH
  - REG_ZERO (5'd0)
  - the legal-range limits for LU_STALL_CYCLES and FLUSH_CYCLES
- Sub-module `sat_counter` (width parameter, inc, clear) is instantiated twice, only under HAZARD_PERF_CNT_EN.
- Hazard compare and the FSM live in this module.

## Test plan
- id_ex_memRead=1, id_ex_rt=5, if_id_rs=5, LU_STALL_CYCLES=2 → stall=1, pc_write=0 for exactly 2 cycles (the second with memRead=0), then pass.
- id_ex_memRead=1, id_ex_rt=0, if_id_rs=0 → no stall.
- branch_taken pulse 1 cycle, FLUSH_CYCLES=2 → flush=1 for 2 cycles, pc_write=1 throughout, ctrl_state 0→2→0.
- branch_taken in the 2nd cycle of a 3-cycle STALL → flush that cycle, stall=0, enter FLUSH, with no further stall.
- reset=0 asserted mid-FLUSH → next cycle ctrl_state=0 and outputs forced low. After release, a hit produces a fresh sequence.
- HAZARD_PERF_CNT_EN, CNT_W=4: 20 back-to-back load-use hits → stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, the hardwired-zero register index and the legal ranges of the
// bubble/flush length parameters.
package pipe_ctrl_pkg;

    // FSM state encoding; ctrl_state exposes these values for debug.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_e;

    // $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Legal ranges: the 2-bit remaining-cycle counter holds at most 3-1.
    localparam int LU_STALL_MIN = 1;
    localparam int LU_STALL_MAX = 3;
    localparam int FLUSH_MIN    = 1;
    localparam int FLUSH_MAX    = 3;

    // Pin a cycle-count parameter into its legal range so an out-of-range
    // override cannot overflow the remaining-cycle counter.
    function automatic int clamp_cycles(input int val, input int lo, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Holds at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count events, sticking at the maximum value.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS-32 core.
// Detects load-use hazards and inserts LU_STALL_CYCLES bubbles, and holds
// flush for FLUSH_CYCLES cycles after a taken branch. Outputs are
// combinational from the registered state/rem and the current inputs so
// the pipeline-register enables react in the same cycle.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles and
// flush_cycles saturating performance counters (width CNT_W).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 2
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W           = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_memRead,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic [1:0]       ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
`endif
);

    localparam int LU_CYC = clamp_cycles(LU_STALL_CYCLES, LU_STALL_MIN, LU_STALL_MAX);
    localparam int FL_CYC = clamp_cycles(FLUSH_CYCLES, FLUSH_MIN, FLUSH_MAX);

    // rem value loaded on entry: the entry cycle itself is the first one.
    localparam logic [1:0] LU_REM = 2'(LU_CYC - 1);
    localparam logic [1:0] FL_REM = 2'(FL_CYC - 1);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic [1:0]  rem_q;
    logic [1:0]  rem_d;
    logic        lu_hit;

    // Load in EX writes a register the instruction in ID reads ($zero excluded).
    assign lu_hit = id_ex_memRead && (id_ex_rt != REG_ZERO) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    // Output decode and next-state logic; reset forces every enable low.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        stall       = 1'b0;
        flush       = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;

        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    flush = 1'b1;
                    if (FL_CYC > 1) begin
                        state_d = FLUSH;
                        rem_d   = FL_REM;
                    end
                end else if (lu_hit) begin
                    stall       = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if (LU_CYC > 1) begin
                        state_d = STALL;
                        rem_d   = LU_REM;
                    end
                end
            end

            STALL: begin
                if (branch_taken) begin
                    // The stalled instruction is wrong-path: drop the stall.
                    flush = 1'b1;
                    if (FL_CYC > 1) begin
                        state_d = FLUSH;
                        rem_d   = FL_REM;
                    end else begin
                        state_d = RUN;
                        rem_d   = 2'd0;
                    end
                end else begin
                    // The first bubble cleared id_ex_memRead, so the hazard
                    // is carried here rather than re-detected.
                    stall       = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if (rem_q <= 2'd1) begin
                        state_d = RUN;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
            end

            FLUSH: begin
                // Hazards and branches seen here belong to wrong-path code.
                flush = 1'b1;
                if (rem_q <= 2'd1) begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end else begin
                    rem_d = rem_q - 2'd1;
                end
            end

            default: begin
                state_d = RUN;
                rem_d   = 2'd0;
            end
        endcase

        if (!reset) begin
            stall       = 1'b0;
            flush       = 1'b0;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end
    end

    assign ctrl_state = reset ? state_q : RUN;

    // State and remaining-cycle registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all registers updating from
        // the same pre-edge values.
        if (!reset) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (!reset),
        .inc   (stall),
        .count (stall_cycles)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .clear (!reset),
        .inc   (flush),
        .count (flush_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Two instances with different
// bubble/flush lengths share one stimulus stream; a cycle-count model of
// the hazard rules predicts every output each cycle.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_ex_memRead;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       branch_taken;

    logic [1:0] stall_o;
    logic [1:0] flush_o;
    logic [1:0] pc_o;
    logic [1:0] ifid_o;
    logic [1:0] state_o [2];
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] scnt_o [2];
    logic [3:0] fcnt_o [2];
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    // Model configuration per instance: bubbles and flush length.
    int lu_p [2] = '{2, 3};
    int fl_p [2] = '{2, 3};

    // Model state: committed cycles still owed after the current one.
    int stall_left [2] = '{0, 0};
    int flush_left [2] = '{0, 0};
    int cnt_s      [2] = '{0, 0};
    int cnt_f      [2] = '{0, 0};
    localparam int CNT_MAX = 15;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .LU_STALL_CYCLES (2),
        .FLUSH_CYCLES    (2)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .CNT_W           (4)
`endif
    ) dut_a (
        .clk           (clk),
        .reset         (reset),
        .id_ex_memRead (id_ex_memRead),
        .id_ex_rt      (id_ex_rt),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .branch_taken  (branch_taken),
        .stall         (stall_o[0]),
        .flush         (flush_o[0]),
        .pc_write      (pc_o[0]),
        .if_id_write   (ifid_o[0]),
        .ctrl_state    (state_o[0])
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles  (scnt_o[0]),
        .flush_cycles  (fcnt_o[0])
`endif
    );

    pipe_hazard_ctrl #(
        .LU_STALL_CYCLES (3),
        .FLUSH_CYCLES    (3)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .CNT_W           (4)
`endif
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .id_ex_memRead (id_ex_memRead),
        .id_ex_rt      (id_ex_rt),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .branch_taken  (branch_taken),
        .stall         (stall_o[1]),
        .flush         (flush_o[1]),
        .pc_write      (pc_o[1]),
        .if_id_write   (ifid_o[1]),
        .ctrl_state    (state_o[1])
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles  (scnt_o[1]),
        .flush_cycles  (fcnt_o[1])
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hazard_now();
        return id_ex_memRead && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    endfunction

    // Predict this cycle's outputs for instance d, compare, then advance
    // the model across the coming clock edge.
    task automatic model_cycle(input int d);
        logic e_stall, e_flush, e_pc, e_ifid;
        int   e_state;
        e_stall = 1'b0;
        e_flush = 1'b0;
        e_pc    = 1'b0;
        e_ifid  = 1'b0;
        e_state = 0;
        if (reset) begin
            e_state = (flush_left[d] > 0) ? 2 : ((stall_left[d] > 0) ? 1 : 0);
            e_pc    = 1'b1;
            e_ifid  = 1'b1;
            if (flush_left[d] > 0) begin
                e_flush = 1'b1;
                flush_left[d]--;
            end else if (branch_taken) begin
                e_flush       = 1'b1;
                flush_left[d] = fl_p[d] - 1;
                stall_left[d] = 0;
            end else if (stall_left[d] > 0) begin
                e_stall = 1'b1;
                e_pc    = 1'b0;
                e_ifid  = 1'b0;
                stall_left[d]--;
            end else if (hazard_now()) begin
                e_stall       = 1'b1;
                e_pc          = 1'b0;
                e_ifid        = 1'b0;
                stall_left[d] = lu_p[d] - 1;
            end
        end else begin
            stall_left[d] = 0;
            flush_left[d] = 0;
        end

        check($sformatf("stall[%0d]", d),       16'(stall_o[d]),  16'(e_stall));
        check($sformatf("flush[%0d]", d),       16'(flush_o[d]),  16'(e_flush));
        check($sformatf("pc_write[%0d]", d),    16'(pc_o[d]),     16'(e_pc));
        check($sformatf("if_id_write[%0d]", d), 16'(ifid_o[d]),   16'(e_ifid));
        check($sformatf("ctrl_state[%0d]", d),  16'(state_o[d]),  16'(e_state));
`ifdef HAZARD_PERF_CNT_EN
        check($sformatf("stall_cycles[%0d]", d), 16'(scnt_o[d]), 16'(cnt_s[d]));
        check($sformatf("flush_cycles[%0d]", d), 16'(fcnt_o[d]), 16'(cnt_f[d]));
`endif
        if (!reset) begin
            cnt_s[d] = 0;
            cnt_f[d] = 0;
        end else begin
            if (e_stall && cnt_s[d] < CNT_MAX) cnt_s[d]++;
            if (e_flush && cnt_f[d] < CNT_MAX) cnt_f[d]++;
        end
    endtask

    // Apply one cycle of inputs mid-period and check both instances.
    task automatic cycle(input logic r, input logic mr, input logic [4:0] rt,
                         input logic [4:0] rs, input logic [4:0] rt2, input logic br);
        @(negedge clk);
        reset         = r;
        id_ex_memRead = mr;
        id_ex_rt      = rt;
        if_id_rs      = rs;
        if_id_rt      = rt2;
        branch_taken  = br;
        #1;
        for (int d = 0; d < 2; d++) model_cycle(d);
    endtask

    initial begin
        reset         = 1'b0;
        id_ex_memRead = 1'b0;
        id_ex_rt      = 5'd0;
        if_id_rs      = 5'd0;
        if_id_rt      = 5'd0;
        branch_taken  = 1'b0;

        // Reset: everything forced low.
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Load-use on rs, then bubbles with memRead cleared.
        cycle(1'b1, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 5'd5, 5'd5, 5'd1, 1'b0);

        // Load-use on rt.
        cycle(1'b1, 1'b1, 5'd7, 5'd2, 5'd7, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 5'd0, 5'd2, 5'd7, 1'b0);

        // Destination $zero never stalls.
        cycle(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0);

        // Single-cycle branch pulse.
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Branch in the second stall cycle aborts the stall.
        cycle(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
        cycle(1'b1, 1'b0, 5'd4, 5'd4, 5'd0, 1'b1);
        repeat (4) cycle(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);

        // Hazard and branch during FLUSH are ignored.
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Reset in the middle of FLUSH, then a fresh hazard sequence.
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0);

        // Back-to-back load-use hits: counters run into saturation.
        repeat (40) cycle(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_sat[0]", 16'(scnt_o[0]), 16'd15);
        check("stall_sat[1]", 16'(scnt_o[1]), 16'd15);
`endif

        // Randomized traffic over a small register set for frequent hits.
        repeat (600) begin
            cycle(($urandom_range(0, 49) != 0),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
